// File: rtl/vscale_hazard_unit.sv
// Scoreboard-based register hazard, bypass select and in-flight tracking for the vscale pipeline.
// Tracks DEPTH post-issue stages; stage DEPTH drives the register-file write port.
module vscale_hazard_unit #(
    parameter int DEPTH      = 2,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 2,
    parameter int MUL_LAT    = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic                  kill_DX,
    input  logic                  issue_wr,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [1:0]            issue_class,
    input  logic                  rs1_used,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  stall_ext,
    input  logic                  flush,
    output logic [SEL_W-1:0]      bypass_rs1_sel,
    output logic [SEL_W-1:0]      bypass_rs2_sel,
    output logic                  stall_DX,
    output logic                  wr_en_WB,
    output logic [REG_ADDR_W-1:0] wr_addr_WB,
    output logic [SEL_W-1:0]      inflight_count,
    output logic                  busy
);

    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_LONG = 2'd2;

    // Array index i holds scoreboard stage i+1.
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_wr;
    logic [REG_ADDR_W-1:0] r_rd  [DEPTH];
    logic [1:0]            r_cls [DEPTH];
    logic [SEL_W-1:0]      r_count;

    logic [DEPTH-1:0]      w_ready;
    logic [DEPTH-1:0]      w_hit1;
    logic [DEPTH-1:0]      w_hit2;
    logic [SEL_W-1:0]      w_rs1_sel;
    logic [SEL_W-1:0]      w_rs2_sel;
    logic                  w_rs1_haz;
    logic                  w_rs2_haz;
    logic                  w_stall_dx;
    logic                  w_accept;
    logic                  w_leave;
    logic [SEL_W-1:0]      w_count_d;

    function automatic int class_lat(input logic [1:0] cls);
        int lat;
        case (cls)
            CLS_LOAD: lat = LOAD_LAT;
            CLS_LONG: lat = MUL_LAT;
            default:  lat = 1;
        endcase
        return lat;
    endfunction

    always_comb begin
        w_ready = '0;
        w_hit1  = '0;
        w_hit2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = ((i + 1) >= class_lat(r_cls[i]));
            w_hit1[i]  = r_valid[i] && r_wr[i] && (r_rd[i] == rs1_addr);
            w_hit2[i]  = r_valid[i] && r_wr[i] && (r_rd[i] == rs2_addr);
        end
    end

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        w_rs1_sel = '0;
        w_rs1_haz = 1'b0;
        if (rs1_used && (rs1_addr != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (w_hit1[i]) begin
                    w_rs1_sel = w_ready[i] ? SEL_W'(i + 1) : '0;
                    w_rs1_haz = !w_ready[i];
                end
            end
        end
    end

    always_comb begin
        w_rs2_sel = '0;
        w_rs2_haz = 1'b0;
        if (rs2_used && (rs2_addr != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (w_hit2[i]) begin
                    w_rs2_sel = w_ready[i] ? SEL_W'(i + 1) : '0;
                    w_rs2_haz = !w_ready[i];
                end
            end
        end
    end

    assign w_stall_dx = stall_ext || (issue_valid && (w_rs1_haz || w_rs2_haz));
    assign w_accept   = issue_valid && !kill_DX && !w_stall_dx && !flush;
    assign w_leave    = r_valid[DEPTH-1];

    always_comb begin
        w_count_d = r_count;
        if (w_accept && !w_leave) begin
            w_count_d = r_count + SEL_W'(1);
        end else if (!w_accept && w_leave) begin
            w_count_d = r_count - SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]  <= '0;
                r_cls[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (!stall_ext) begin
            r_valid[0] <= w_accept;
            r_wr[0]    <= w_accept && issue_wr;
            r_rd[0]    <= issue_rd;
            r_cls[0]   <= issue_class;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_wr[i]    <= r_wr[i-1];
                r_rd[i]    <= r_rd[i-1];
                r_cls[i]   <= r_cls[i-1];
            end
            r_count <= w_count_d;
        end
    end

    assign bypass_rs1_sel = w_rs1_sel;
    assign bypass_rs2_sel = w_rs2_sel;
    assign stall_DX       = w_stall_dx;
    // x0 writes are suppressed here so the register file never sees them.
    assign wr_en_WB       = r_valid[DEPTH-1] && r_wr[DEPTH-1] && (r_rd[DEPTH-1] != '0)
                            && !stall_ext && !flush;
    assign wr_addr_WB     = r_rd[DEPTH-1];
    assign inflight_count = r_count;
    assign busy           = (r_count != '0);

endmodule

// File: tb/tb_vscale_hazard_unit.sv
// Directed scoreboard bench for vscale_hazard_unit (DEPTH=3, LOAD_LAT=2, MUL_LAT=3).
module tb_vscale_hazard_unit;

    localparam int DEPTH = 3;
    localparam int AW    = 5;
    localparam int SW    = 2;

    localparam int F_SEL1 = 0, F_SEL2 = 1, F_STALL = 2, F_WREN = 3;
    localparam int F_WADDR = 4, F_COUNT = 5, F_BUSY = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_valid, kill_DX, issue_wr;
    logic [AW-1:0] issue_rd;
    logic [1:0]    issue_class;
    logic          rs1_used, rs2_used;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic          stall_ext, flush;
    logic [SW-1:0] bypass_rs1_sel, bypass_rs2_sel;
    logic          stall_DX, wr_en_WB;
    logic [AW-1:0] wr_addr_WB;
    logic [SW-1:0] inflight_count;
    logic          busy;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    q_cyc[$];
    int    q_fld[$];
    int    q_exp[$];
    string q_name[$];

    vscale_hazard_unit #(
        .DEPTH(DEPTH), .REG_ADDR_W(AW), .LOAD_LAT(2), .MUL_LAT(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .kill_DX(kill_DX), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_class(issue_class),
        .rs1_used(rs1_used), .rs1_addr(rs1_addr), .rs2_used(rs2_used), .rs2_addr(rs2_addr),
        .stall_ext(stall_ext), .flush(flush),
        .bypass_rs1_sel(bypass_rs1_sel), .bypass_rs2_sel(bypass_rs2_sel),
        .stall_DX(stall_DX), .wr_en_WB(wr_en_WB), .wr_addr_WB(wr_addr_WB),
        .inflight_count(inflight_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dut_field(input int f);
        case (f)
            F_SEL1:  return int'(bypass_rs1_sel);
            F_SEL2:  return int'(bypass_rs2_sel);
            F_STALL: return int'(stall_DX);
            F_WREN:  return int'(wr_en_WB);
            F_WADDR: return int'(wr_addr_WB);
            F_COUNT: return int'(inflight_count);
            default: return int'(busy);
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle, mid-cycle.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int    c, f, e, a;
            string n;
            c = q_cyc.pop_front();
            f = q_fld.pop_front();
            e = q_exp.pop_front();
            n = q_name.pop_front();
            checks++;
            if (c < cyc) begin
                errors++;
                $display("FAIL %s cyc=%0d not sampled in time (now %0d)", n, c, cyc);
            end else begin
                a = dut_field(f);
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cyc=%0d actual=%0d required=%0d", n, c, a, e);
                end
            end
        end
    end

    task automatic push_exp(input string n, input int f, input int v);
        q_cyc.push_back(cyc);
        q_fld.push_back(f);
        q_exp.push_back(v);
        q_name.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0; issue_class = '0;
        rs1_used = 1'b0; rs1_addr = '0; rs2_used = 1'b0; rs2_addr = '0;
        kill_DX = 1'b0;
    endtask

    task automatic issue(input logic wr, input int rd, input int cls,
                         input logic u1, input int a1, input logic u2, input int a2);
        issue_valid = 1'b1; kill_DX = 1'b0;
        issue_wr = wr; issue_rd = AW'(rd); issue_class = 2'(cls);
        rs1_used = u1; rs1_addr = AW'(a1); rs2_used = u2; rs2_addr = AW'(a2);
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        idle();
        tick();
        // Reset state, with stall_ext passing straight through.
        stall_ext = 1'b1;
        push_exp("rst_sel1", F_SEL1, 0);   push_exp("rst_sel2", F_SEL2, 0);
        push_exp("rst_stall", F_STALL, 1); push_exp("rst_wren", F_WREN, 0);
        push_exp("rst_count", F_COUNT, 0); push_exp("rst_busy", F_BUSY, 0);
        tick();
        stall_ext = 1'b0; reset_n = 1'b1;
        push_exp("rst_stall_rel", F_STALL, 0);

        // ALU x5 then consumer.
        tick(); issue(1, 5, 0, 0, 0, 0, 0);
        push_exp("alu_stall", F_STALL, 0);
        tick(); issue(0, 0, 0, 1, 5, 0, 0);
        push_exp("alu_sel1", F_SEL1, 1); push_exp("alu_nostall", F_STALL, 0);
        push_exp("alu_count1", F_COUNT, 1);
        tick(); idle();
        push_exp("alu_wren_early", F_WREN, 0); push_exp("alu_count2", F_COUNT, 2);
        tick();
        push_exp("alu_wren", F_WREN, 1); push_exp("alu_waddr", F_WADDR, 5);
        push_exp("alu_count2b", F_COUNT, 2);
        tick();
        push_exp("alu_wren_cons", F_WREN, 0); push_exp("alu_count1b", F_COUNT, 1);
        tick();
        push_exp("alu_count0", F_COUNT, 0); push_exp("alu_busy0", F_BUSY, 0);

        // Load x7 then consumer on rs2: one stall cycle.
        tick(); issue(1, 7, 1, 0, 0, 0, 0);
        tick(); issue(0, 0, 0, 0, 0, 1, 7);
        push_exp("ld_stall", F_STALL, 1); push_exp("ld_sel2_haz", F_SEL2, 0);
        push_exp("ld_count_a", F_COUNT, 1);
        tick();
        push_exp("ld_stall_done", F_STALL, 0); push_exp("ld_sel2", F_SEL2, 2);
        push_exp("ld_count_b", F_COUNT, 1);
        tick(); idle();
        push_exp("ld_wren", F_WREN, 1); push_exp("ld_waddr", F_WADDR, 7);
        push_exp("ld_count_c", F_COUNT, 2);
        drain(3);
        push_exp("ld_drain", F_COUNT, 0);

        // Long-latency x9, consumer on both operands: two stall cycles.
        tick(); issue(1, 9, 2, 0, 0, 0, 0);
        tick(); issue(0, 0, 0, 1, 9, 1, 9);
        push_exp("mul_stall1", F_STALL, 1); push_exp("mul_count", F_COUNT, 1);
        tick();
        push_exp("mul_stall2", F_STALL, 1);
        tick();
        push_exp("mul_nostall", F_STALL, 0); push_exp("mul_sel1", F_SEL1, 3);
        push_exp("mul_sel2", F_SEL2, 3); push_exp("mul_wren", F_WREN, 1);
        push_exp("mul_waddr", F_WADDR, 9); push_exp("mul_count_d", F_COUNT, 1);
        tick(); idle();
        push_exp("mul_count_swap", F_COUNT, 1);
        drain(3);
        push_exp("mul_drain", F_COUNT, 0);

        // Youngest match wins; x0 never matches nor writes back.
        tick(); issue(1, 3, 0, 0, 0, 0, 0);
        tick(); issue(1, 3, 0, 0, 0, 0, 0);
        tick(); issue(0, 0, 0, 1, 3, 0, 0);
        push_exp("young_sel1", F_SEL1, 1); push_exp("young_stall", F_STALL, 0);
        tick(); issue(1, 0, 0, 0, 0, 0, 0);
        push_exp("x3a_wren", F_WREN, 1); push_exp("x3a_waddr", F_WADDR, 3);
        tick(); issue(0, 0, 0, 1, 0, 1, 0);
        push_exp("x0_sel1", F_SEL1, 0); push_exp("x0_sel2", F_SEL2, 0);
        push_exp("x0_stall", F_STALL, 0); push_exp("x3b_wren", F_WREN, 1);
        tick(); idle();
        push_exp("rdr_wren", F_WREN, 0);
        tick();
        push_exp("x0_wren", F_WREN, 0); push_exp("x0_count", F_COUNT, 2);
        drain(2);
        push_exp("x0_drain", F_COUNT, 0);

        // Fill, external stall freezes everything, flush during the stall.
        tick(); issue(1, 10, 0, 0, 0, 0, 0);
        tick(); issue(1, 11, 0, 0, 0, 0, 0);
        tick(); issue(1, 12, 0, 0, 0, 0, 0);
        tick(); idle(); stall_ext = 1'b1;
        push_exp("ext_wren", F_WREN, 0); push_exp("ext_count", F_COUNT, 3);
        push_exp("ext_stall", F_STALL, 1);
        tick(); issue(0, 0, 0, 1, 11, 1, 10);
        push_exp("ext_frz_sel1", F_SEL1, 2); push_exp("ext_frz_sel2", F_SEL2, 3);
        push_exp("ext_frz_wren", F_WREN, 0); push_exp("ext_frz_count", F_COUNT, 3);
        tick(); idle(); flush = 1'b1;
        push_exp("fl_wren", F_WREN, 0); push_exp("fl_count_pre", F_COUNT, 3);
        tick(); stall_ext = 1'b0; flush = 1'b0; issue(0, 0, 0, 1, 11, 1, 12);
        push_exp("fl_count", F_COUNT, 0); push_exp("fl_busy", F_BUSY, 0);
        push_exp("fl_sel1", F_SEL1, 0); push_exp("fl_sel2", F_SEL2, 0);
        push_exp("fl_stall", F_STALL, 0);
        drain(3);
        push_exp("fl_drain", F_COUNT, 0);

        // Async reset with two entries in flight, then kill and a fresh accept.
        tick(); issue(1, 13, 0, 0, 0, 0, 0);
        tick(); issue(1, 14, 0, 0, 0, 0, 0);
        tick(); idle();
        push_exp("ar_count_pre", F_COUNT, 2);
        tick(); issue(0, 0, 0, 1, 13, 0, 0);
        reset_n = 1'b0;
        #1;
        push_exp("ar_count", F_COUNT, 0); push_exp("ar_wren", F_WREN, 0);
        push_exp("ar_busy", F_BUSY, 0); push_exp("ar_sel1", F_SEL1, 0);
        tick(); reset_n = 1'b1; issue(1, 16, 0, 0, 0, 0, 0); kill_DX = 1'b1;
        push_exp("ar_count_rel", F_COUNT, 0);
        tick(); issue(1, 15, 0, 0, 0, 0, 0);
        push_exp("kill_count", F_COUNT, 0);
        tick(); idle();
        push_exp("ar_first_count", F_COUNT, 1); push_exp("ar_first_busy", F_BUSY, 1);
        drain(3);

        if (q_cyc.size() != 0) begin
            checks += q_cyc.size();
            errors += q_cyc.size();
            $display("FAIL scoreboard_leftover count=%0d required=0", q_cyc.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
